// File: rtl/multirate_mac_sched.sv
// multirate_mac_sched: round-robin arbiter that lends one shared
// 16x11 product multiplier to N_REQ filter phases. Each granted job
// streams TAPS operand pairs, accumulates the products and returns a
// single tagged dot product.
module multirate_mac_sched #(
  parameter int N_REQ  = 4,
  parameter int TAPS   = 16,
  parameter int ADDR_W = 4,
  parameter int ID_W   = 2,
  parameter int ACC_W  = 32
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic                     op_en,
  output logic [ID_W-1:0]          op_id,
  output logic [ADDR_W-1:0]        op_addr,
  input  logic signed [15:0]       op_x,
  input  logic [10:0]              op_c,
  output logic signed [15:0]       mul_a,
  output logic [10:0]              mul_b,
  input  logic signed [26:0]       mul_p,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic signed [ACC_W-1:0]  res_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN1,
    S_DRAIN2,
    S_DONE
  } state_t;

  // Accumulation wraps, so the product only needs sign extension.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [26:0] p);
    return {{(ACC_W-27){p[26]}}, p};
  endfunction

  state_t                    state_q,     state_d;
  logic [N_REQ-1:0]          gnt_q,       gnt_d;
  logic [ID_W-1:0]           id_q,        id_d;
  logic [ID_W-1:0]           rr_ptr_q,    rr_ptr_d;
  logic                      op_en_q,     op_en_d;
  logic [ADDR_W-1:0]         op_addr_q,   op_addr_d;
  logic                      vld_p1_q,    vld_p1_d;
  logic                      vld_p2_q,    vld_p2_d;
  logic signed [15:0]        mul_a_q,     mul_a_d;
  logic [10:0]               mul_b_q,     mul_b_d;
  logic signed [ACC_W-1:0]   acc_q,       acc_d;
  logic                      res_valid_q, res_valid_d;
  logic [ID_W-1:0]           res_id_q,    res_id_d;
  logic signed [ACC_W-1:0]   res_data_q,  res_data_d;

  logic                      pick_found;
  logic [ID_W-1:0]           pick_id;
  logic [N_REQ-1:0]          pick_onehot;

  // Round-robin pick: first requesting index at or after rr_ptr, wrapping.
  always_comb begin
    pick_found  = 1'b0;
    pick_id     = '0;
    pick_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int               idx;
      logic [N_REQ-1:0] cand;
      idx  = int'(rr_ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = {{(N_REQ-1){1'b0}}, 1'b1} << idx;
      if (!pick_found && ((req & cand) != '0)) begin
        pick_found  = 1'b1;
        pick_id     = ID_W'(idx);
        pick_onehot = cand;
      end
    end
  end

  // Next-state: job sequencing FSM plus the two-stage operand/accumulate pipe.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    id_d        = id_q;
    rr_ptr_d    = rr_ptr_q;
    op_en_d     = op_en_q;
    op_addr_d   = op_addr_q;
    res_valid_d = 1'b0;
    res_id_d    = res_id_q;
    res_data_d  = res_data_q;

    // p1: operands returned by memory one cycle after op_en are captured
    vld_p1_d = op_en_q;
    mul_a_d  = vld_p1_q ? op_x : mul_a_q;
    mul_b_d  = vld_p1_q ? op_c : mul_b_q;

    // p2: registered operands have been multiplied; fold into accumulator
    vld_p2_d = vld_p1_q;
    acc_d    = vld_p2_q ? (acc_q + sext_prod(mul_p)) : acc_q;

    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          state_d   = S_RUN;
          gnt_d     = pick_onehot;
          id_d      = pick_id;
          acc_d     = '0;
          op_en_d   = 1'b1;
          op_addr_d = '0;
        end
      end
      S_RUN: begin
        op_addr_d = op_addr_q + 1'b1;
        if (op_addr_q == ADDR_W'(TAPS-1)) begin
          op_en_d = 1'b0;
          state_d = S_DRAIN1;
        end
      end
      S_DRAIN1: begin
        state_d = S_DRAIN2;
      end
      S_DRAIN2: begin
        // The last product lands on this edge, so publish the updated sum.
        state_d     = S_DONE;
        res_valid_d = 1'b1;
        res_id_d    = id_q;
        res_data_d  = acc_d;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        gnt_d    = '0;
        rr_ptr_d = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any job in flight.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      id_q        <= '0;
      rr_ptr_q    <= '0;
      op_en_q     <= 1'b0;
      op_addr_q   <= '0;
      vld_p1_q    <= 1'b0;
      vld_p2_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      acc_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      id_q        <= id_d;
      rr_ptr_q    <= rr_ptr_d;
      op_en_q     <= op_en_d;
      op_addr_q   <= op_addr_d;
      vld_p1_q    <= vld_p1_d;
      vld_p2_q    <= vld_p2_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      acc_q       <= acc_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_data_q  <= res_data_d;
    end
  end

  assign gnt       = gnt_q;
  assign op_en     = op_en_q;
  assign op_id     = id_q;
  assign op_addr   = op_addr_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_multirate_mac_sched.sv
// Testbench for multirate_mac_sched: operand memory and multiplier models,
// expected dot products queued at stimulus time, compared on res_valid.
module tb_multirate_mac_sched;

  localparam int N_REQ  = 4;
  localparam int TAPS   = 16;
  localparam int ADDR_W = 4;
  localparam int ID_W   = 2;
  localparam int ACC_W  = 32;

  logic                    ap_clk = 1'b0;
  logic                    ap_rst;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        gnt;
  logic                    op_en;
  logic [ID_W-1:0]         op_id;
  logic [ADDR_W-1:0]       op_addr;
  logic signed [15:0]      op_x;
  logic [10:0]             op_c;
  logic signed [15:0]      mul_a;
  logic [10:0]             mul_b;
  logic signed [26:0]      mul_p;
  logic signed [27:0]      mul_full;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic signed [ACC_W-1:0] res_data;

  typedef struct {
    int id;
    int data;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pat      = 0;
  int   salt     = 0;

  multirate_mac_sched #(
    .N_REQ(N_REQ), .TAPS(TAPS), .ADDR_W(ADDR_W), .ID_W(ID_W), .ACC_W(ACC_W)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .req(req), .gnt(gnt),
    .op_en(op_en), .op_id(op_id), .op_addr(op_addr),
    .op_x(op_x), .op_c(op_c), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .res_valid(res_valid), .res_id(res_id), .res_data(res_data)
  );

  always #5 ap_clk = ~ap_clk;

  // External multiplier: signed A times unsigned B, combinational.
  assign mul_full = $signed(mul_a) * $signed({1'b0, mul_b});
  assign mul_p    = mul_full[26:0];

  function automatic int hsh(int id, int k);
    int h;
    h = id * 7919 + k * 104729 + salt * 31337 + 12345;
    h = h ^ (h >>> 7);
    h = h * 1103515245 + 12345;
    return h;
  endfunction

  function automatic logic signed [15:0] fx(int p, int id, int k);
    int h;
    h = hsh(id, k);
    case (p)
      0:       return 16'sd1;
      1:       return -16'sd32768;
      2:       return 16'(k - 8);
      default: return $signed(h[15:0]);
    endcase
  endfunction

  function automatic logic [10:0] fc(int p, int id, int k);
    int h;
    h = hsh(id, k) >>> 5;
    case (p)
      0:       return 11'd1;
      1:       return 11'd2047;
      2:       return 11'(k);
      default: return h[10:0];
    endcase
  endfunction

  function automatic int exp_dot(int id);
    longint s;
    s = 0;
    for (int k = 0; k < TAPS; k++)
      s += longint'(fx(pat, id, k)) * longint'({1'b0, fc(pat, id, k)});
    return int'(s);
  endfunction

  // Synchronous operand memory; junk on idle cycles must never be captured.
  always @(posedge ap_clk) begin
    if (op_en === 1'b1) begin
      op_x <= fx(pat, int'(op_id), int'(op_addr));
      op_c <= fc(pat, int'(op_id), int'(op_addr));
    end else begin
      op_x <= 16'sh5a5a;
      op_c <= 11'h3c3;
    end
  end

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Result monitor: every pulse must match the oldest queued expectation.
  always @(negedge ap_clk) begin
    exp_t e;
    if (res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_res", longint'(res_id), -1);
      end else begin
        e = sb.pop_front();
        check_eq("res_id", longint'(res_id), e.id);
        check_eq("res_data", longint'(res_data), e.data);
      end
    end
  end

  // Called at cycle 1+k0 (sampled #1 after the edge); returns the cycle of res_valid.
  task automatic wait_res(input int k0, input string tag, output int lat);
    int k;
    bit bad;
    k   = k0;
    bad = 0;
    while (k < 60) begin
      if (k < TAPS && (op_en !== 1'b1 || op_addr !== ADDR_W'(k))) bad = 1;
      if (k >= TAPS && op_en !== 1'b0) bad = 1;
      if (res_valid === 1'b1) break;
      @(posedge ap_clk); #1;
      k++;
    end
    if (res_valid !== 1'b1) check_eq({tag, "_timeout"}, 0, 1);
    check_eq({tag, "_addr_seq"}, bad, 0);
    lat = k + 1;
  endtask

  task automatic run_job(input logic [N_REQ-1:0] reqv, input int id, input string tag);
    int lat;
    @(negedge ap_clk);
    req = reqv;
    sb.push_back('{id, exp_dot(id)});
    @(posedge ap_clk); #1;
    check_eq({tag, "_gnt"}, longint'(gnt), longint'(1 << id));
    req = '0;
    wait_res(0, tag, lat);
    check_eq({tag, "_lat"}, lat, TAPS + 3);
    @(posedge ap_clk); #1;
    check_eq({tag, "_gnt_off"}, longint'(gnt), 0);
    check_eq({tag, "_mul_a_hold"}, longint'(mul_a), longint'(fx(pat, id, TAPS - 1)));
  endtask

  task automatic fair_run(input logic [N_REQ-1:0] reqv, input int npulse, input string tag);
    int t;
    int last;
    int p;
    t    = 0;
    last = 0;
    p    = 0;
    @(negedge ap_clk);
    req = reqv;
    while (p < npulse && t < 40 * npulse) begin
      @(posedge ap_clk); #1;
      t++;
      if (res_valid === 1'b1) begin
        if (p == 0) check_eq({tag, "_first_lat"}, t, TAPS + 3);
        else        check_eq({tag, "_spacing"}, t - last, TAPS + 4);
        last = t;
        p++;
        if (p == npulse) req = '0;
      end
    end
    if (p != npulse) check_eq({tag, "_timeout"}, p, npulse);
    repeat (2) @(posedge ap_clk);
    #1;
    check_eq({tag, "_idle_gnt"}, longint'(gnt), 0);
  endtask

  task automatic do_reset();
    @(negedge ap_clk);
    ap_rst = 1'b1;
    req    = '0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 1'b0;
  endtask

  initial begin
    int  lat;
    bit  bad;
    int  id;
    ap_rst = 1'b1;
    req    = '0;
    repeat (3) @(posedge ap_clk);
    #1;
    check_eq("rst_gnt", longint'(gnt), 0);
    check_eq("rst_op_en", longint'(op_en), 0);
    check_eq("rst_op_id", longint'(op_id), 0);
    check_eq("rst_op_addr", longint'(op_addr), 0);
    check_eq("rst_mul_a", longint'(mul_a), 0);
    check_eq("rst_mul_b", longint'(mul_b), 0);
    check_eq("rst_res_valid", longint'(res_valid), 0);
    check_eq("rst_res_id", longint'(res_id), 0);
    check_eq("rst_res_data", longint'(res_data), 0);
    ap_rst = 1'b0;

    // Basic, signed extremes and mixed operands with spec constants.
    pat = 0;
    run_job(4'b0001, 0, "basic");
    check_eq("basic_const", longint'(res_data), 16);
    pat = 1;
    run_job(4'b0100, 2, "extreme");
    check_eq("extreme_const", longint'(res_data), -1073217536);
    pat = 2;
    run_job(4'b0010, 1, "mixed");
    check_eq("mixed_const", longint'(res_data), 280);

    // Fairness from rr_ptr=0.
    do_reset();
    pat  = 3;
    salt = 1;
    sb.push_back('{0, exp_dot(0)});
    sb.push_back('{1, exp_dot(1)});
    sb.push_back('{2, exp_dot(2)});
    sb.push_back('{3, exp_dot(3)});
    sb.push_back('{0, exp_dot(0)});
    fair_run(4'b1111, 5, "fair_all");
    sb.push_back('{1, exp_dot(1)});
    sb.push_back('{3, exp_dot(3)});
    sb.push_back('{1, exp_dot(1)});
    sb.push_back('{3, exp_dot(3)});
    fair_run(4'b1010, 4, "fair_1010");

    // Request dropped in cycle 3 of its job.
    salt = 2;
    @(negedge ap_clk);
    req = 4'b1000;
    sb.push_back('{3, exp_dot(3)});
    @(posedge ap_clk); #1;
    check_eq("drop_gnt", longint'(gnt), 4'b1000);
    repeat (2) @(posedge ap_clk);
    #1;
    req = '0;
    wait_res(2, "drop", lat);
    check_eq("drop_lat", lat, TAPS + 3);
    bad = 0;
    repeat (25) begin
      @(posedge ap_clk); #1;
      if (gnt !== '0 || res_valid !== 1'b0) bad = 1;
    end
    check_eq("drop_no_regrant", bad, 0);

    // Reset in cycle 6 of a job.
    salt = 3;
    @(negedge ap_clk);
    req = 4'b0100;
    @(posedge ap_clk); #1;
    check_eq("rstjob_gnt", longint'(gnt), 4'b0100);
    req = '0;
    repeat (5) @(posedge ap_clk);
    #1;
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    check_eq("rstjob_gnt_off", longint'(gnt), 0);
    check_eq("rstjob_op_en_off", longint'(op_en), 0);
    check_eq("rstjob_mul_a", longint'(mul_a), 0);
    bad = 0;
    repeat (25) begin
      @(posedge ap_clk); #1;
      if (res_valid !== 1'b0 || gnt !== '0) bad = 1;
    end
    check_eq("rstjob_no_result", bad, 0);
    run_job(4'b0010, 1, "after_rst");

    // Random single-requester jobs.
    for (int r = 0; r < 4; r++) begin
      salt = 10 + r;
      id   = int'($urandom_range(0, N_REQ - 1));
      run_job(4'(1 << id), id, "rand");
    end

    repeat (3) @(posedge ap_clk);
    #1;
    check_eq("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
